// File: rtl/uop_debounce2.sv
// uop_debounce2: two-channel synchroniser and debouncer with registered rise/fall event pulses
module uop_debounce2 #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic n_reset,
  input  logic raw_x,
  input  logic raw_y,
  output logic x,
  output logic y,
  output logic x_rise,
  output logic x_fall,
  output logic y_rise,
  output logic y_fall
);
  typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit DIRECT = (STABLE_CYCLES == 1);
  logic [1:0] raw, lvl, rise, fall;
  assign raw = {raw_y, raw_x};
  assign {y, x} = lvl;
  assign {y_rise, x_rise} = rise;
  assign {y_fall, x_fall} = fall;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic s1, s, out_q, rise_q, fall_q, out_n, rise_n, fall_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    state_t state, state_n;
    assign lvl[c] = out_q;
    assign rise[c] = rise_q;
    assign fall[c] = fall_q;
    // two-flop synchroniser followed by the debounce state, counter and registered outputs
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        s1     <= 1'b0;
        s      <= 1'b0;
        state  <= LOW;
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s1     <= raw[c];
        s      <= s1;
        state  <= state_n;
        cnt    <= cnt_n;
        out_q  <= out_n;
        rise_q <= rise_n;
        fall_q <= fall_n;
      end
    end
    // a differing sample opens a wait; an agreeing sample aborts it; the last differing sample flips the level
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      out_n   = out_q;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      case (state)
        LOW:
          if (s) begin
            if (DIRECT) begin
              state_n = HIGH;
              out_n   = 1'b1;
              rise_n  = 1'b1;
            end else begin
              state_n = WAIT_HI;
              cnt_n   = CNT_W'(1);
            end
          end
        WAIT_HI:
          if (!s) begin
            state_n = LOW;
            cnt_n   = '0;
          end else if (cnt == LAST) begin
            state_n = HIGH;
            cnt_n   = '0;
            out_n   = 1'b1;
            rise_n  = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        HIGH:
          if (!s) begin
            if (DIRECT) begin
              state_n = LOW;
              out_n   = 1'b0;
              fall_n  = 1'b1;
            end else begin
              state_n = WAIT_LO;
              cnt_n   = CNT_W'(1);
            end
          end
        WAIT_LO:
          if (s) begin
            state_n = HIGH;
            cnt_n   = '0;
          end else if (cnt == LAST) begin
            state_n = LOW;
            cnt_n   = '0;
            out_n   = 1'b0;
            fall_n  = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
      endcase
    end
  end
endmodule

// File: tb/tb_uop_debounce2.sv
// tb_uop_debounce2: scoreboard bench for the debouncer at STABLE_CYCLES=4 and STABLE_CYCLES=1
module tb_uop_debounce2;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic raw_x = 1'b0, raw_y = 1'b0, raw1_x = 1'b0, raw1_y = 1'b0;
  logic x, y, x_rise, x_fall, y_rise, y_fall;
  logic x1, y1, x1_rise, x1_fall, y1_rise, y1_fall;
  logic [7:0] pv;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {int cyc; logic [7:0] pv;} exp_t;
  exp_t sb[$];
  exp_t e;

  uop_debounce2 dut (
    .clk(clk), .n_reset(n_reset), .raw_x(raw_x), .raw_y(raw_y),
    .x(x), .y(y), .x_rise(x_rise), .x_fall(x_fall), .y_rise(y_rise), .y_fall(y_fall)
  );

  uop_debounce2 #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .raw_x(raw1_x), .raw_y(raw1_y),
    .x(x1), .y(y1), .x_rise(x1_rise), .x_fall(x1_fall), .y_rise(y1_rise), .y_fall(y1_fall)
  );

  assign pv = {y1_fall, y1_rise, x1_fall, x1_rise, y_fall, y_rise, x_fall, x_rise};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) step();
    checks++;
    if ({x, y, x1, y1, pv} !== 12'h000) begin
      failures++;
      $display("FAIL reset_hold got=%h expected=000", {x, y, x1, y1, pv});
    end
    n_reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({x, y, x1, y1, pv} !== 12'h000) begin
      failures++;
      $display("FAIL reset_release got=%h expected=000", {x, y, x1, y1, pv});
    end
  endtask

  task automatic test_clean_step;
    int t;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin raw_x = 1'b1; t = cyc; sb.push_back('{cyc + 6, 8'h01}); end
      if (k == 10) begin raw_x = 1'b0; sb.push_back('{cyc + 6, 8'h02}); end
      step();
      if (pv !== 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL clean_step unexpected pulse cyc=%0d got=%h expected none", cyc, pv);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.pv !== pv) begin
            failures++;
            $display("FAIL clean_step pulse got cyc=%0d pv=%h expected cyc=%0d pv=%h", cyc, pv, e.cyc, e.pv);
          end
        end
      end
      if (cyc == t + 5 || cyc == t + 6) begin
        checks++;
        if ({x, y} !== {cyc == t + 6, 1'b0}) begin
          failures++;
          $display("FAIL clean_step level cyc=%0d got x=%b y=%b expected x=%b y=0", cyc, x, y, cyc == t + 6);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL clean_step missing %0d pulses, next expected cyc=%0d pv=%h", sb.size(), sb[0].cyc, sb[0].pv);
      sb.delete();
    end
  endtask

  task automatic test_bounce;
    logic seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 30; k++) begin
      if (k < 6) raw_x = seq[k];
      if (k == 5) sb.push_back('{cyc + 6, 8'h01});
      if (k == 16) begin raw_x = 1'b0; sb.push_back('{cyc + 6, 8'h02}); end
      step();
      if (pv !== 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL bounce unexpected pulse cyc=%0d got=%h expected none", cyc, pv);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.pv !== pv) begin
            failures++;
            $display("FAIL bounce pulse got cyc=%0d pv=%h expected cyc=%0d pv=%h", cyc, pv, e.cyc, e.pv);
          end
        end
      end
      if (k == 8) begin
        checks++;
        if (x !== 1'b0) begin
          failures++;
          $display("FAIL bounce early_level got x=%b expected x=0", x);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || x !== 1'b0) begin
      failures++;
      $display("FAIL bounce end missing=%0d x=%b expected missing=0 x=0", sb.size(), x);
      sb.delete();
    end
  endtask

  task automatic test_glitch;
    for (int k = 0; k < 28; k++) begin
      if (k == 0) raw_y = 1'b1;
      if (k == 3) raw_y = 1'b0;
      if (k == 12) begin raw_y = 1'b1; sb.push_back('{cyc + 6, 8'h04}); end
      if (k == 16) begin raw_y = 1'b0; sb.push_back('{cyc + 6, 8'h08}); end
      step();
      if (pv !== 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL glitch unexpected pulse cyc=%0d got=%h expected none", cyc, pv);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.pv !== pv) begin
            failures++;
            $display("FAIL glitch pulse got cyc=%0d pv=%h expected cyc=%0d pv=%h", cyc, pv, e.cyc, e.pv);
          end
        end
      end
      if (k == 11 || k == 18) begin
        checks++;
        if (y !== (k == 18)) begin
          failures++;
          $display("FAIL glitch level k=%0d got y=%b expected y=%b", k, y, k == 18);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || y !== 1'b0) begin
      failures++;
      $display("FAIL glitch end missing=%0d y=%b expected missing=0 y=0", sb.size(), y);
      sb.delete();
    end
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin raw_x = 1'b1; raw_y = 1'b1; sb.push_back('{cyc + 6, 8'h05}); end
      if (k == 10) begin raw_x = 1'b0; raw_y = 1'b0; sb.push_back('{cyc + 6, 8'h0a}); end
      step();
      if (pv !== 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL simultaneous unexpected pulse cyc=%0d got=%h expected none", cyc, pv);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.pv !== pv) begin
            failures++;
            $display("FAIL simultaneous pulse got cyc=%0d pv=%h expected cyc=%0d pv=%h", cyc, pv, e.cyc, e.pv);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL simultaneous missing %0d pulses", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_stable1;
    int t = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin raw1_x = 1'b1; sb.push_back('{cyc + 3, 8'h10}); end
      if (k == 6) begin raw1_x = 1'b0; sb.push_back('{cyc + 3, 8'h20}); end
      if (k == 12) begin raw1_x = 1'b1; t = cyc; sb.push_back('{cyc + 3, 8'h10}); end
      if (k == 13) begin raw1_x = 1'b0; sb.push_back('{cyc + 3, 8'h20}); end
      step();
      if (pv !== 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stable1 unexpected pulse cyc=%0d got=%h expected none", cyc, pv);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.pv !== pv) begin
            failures++;
            $display("FAIL stable1 pulse got cyc=%0d pv=%h expected cyc=%0d pv=%h", cyc, pv, e.cyc, e.pv);
          end
        end
      end
      if (k > 12 && (cyc == t + 3 || cyc == t + 4)) begin
        checks++;
        if (x1 !== (cyc == t + 3)) begin
          failures++;
          $display("FAIL stable1 level cyc=%0d got x=%b expected x=%b", cyc, x1, cyc == t + 3);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL stable1 missing %0d pulses", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) begin raw_x = 1'b1; sb.push_back('{cyc + 6, 8'h01}); end
      if (k == 3) raw_y = 1'b1;
      if (k == 8) begin
        checks++;
        if ({x, y} !== 2'b10) begin
          failures++;
          $display("FAIL reset_mid before got x=%b y=%b expected x=1 y=0", x, y);
        end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if ({x, y, pv} !== 10'h000) begin
          failures++;
          $display("FAIL reset_mid async got=%h expected=000", {x, y, pv});
        end
      end
      if (k == 10) begin n_reset = 1'b1; sb.push_back('{cyc + 6, 8'h05}); end
      if (k == 20) begin raw_x = 1'b0; raw_y = 1'b0; sb.push_back('{cyc + 6, 8'h0a}); end
      step();
      if (pv !== 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL reset_mid unexpected pulse cyc=%0d got=%h expected none", cyc, pv);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.pv !== pv) begin
            failures++;
            $display("FAIL reset_mid pulse got cyc=%0d pv=%h expected cyc=%0d pv=%h", cyc, pv, e.cyc, e.pv);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || {x, y} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid end missing=%0d x=%b y=%b expected missing=0 x=0 y=0", sb.size(), x, y);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_stable1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
